// File: rtl/counter_pkg.sv
// Shared constants for up/down modulo counter stages and the clock-chain stage defaults.
package counter_pkg;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam int unsigned SEC_WIDTH = 6;
    localparam int unsigned SEC_MOD   = 59;
    localparam int unsigned MIN_WIDTH = 6;
    localparam int unsigned MIN_MOD   = 59;
    localparam int unsigned HR_WIDTH  = 5;
    localparam int unsigned HR_MOD    = 23;

endpackage

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with runtime terminal value, parallel load, wrap/saturate
// mode and a registered boundary tick for cascading stages.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned RST_VAL = 0,
    parameter int unsigned MODE    = MODE_WRAP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_srst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_cnt_en,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_mod,
    output logic [WIDTH-1:0] o_data,
    output logic             o_tick,
    output logic             o_at_max,
    output logic             o_at_zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             bnd;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        // '>=' so a count stranded above a lowered i_mod wraps on its next up step
        bnd    = i_cnt_en & (i_dir ? (cnt_q >= i_mod) : (cnt_q == '0));

        if (i_srst) begin
            cnt_d = '0;
        end else if (i_load) begin
            cnt_d = (i_load_val > i_mod) ? i_mod : i_load_val;
        end else if (i_cnt_en) begin
            tick_d = bnd;
            if (bnd) begin
                if (MODE == MODE_WRAP) begin
                    cnt_d = i_dir ? '0 : i_mod;
                end
            end else if (i_dir) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q  <= WIDTH'(RST_VAL);
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_data    = cnt_q;
    assign o_tick    = tick_q;
    assign o_at_max  = (cnt_q == i_mod);
    assign o_at_zero = (cnt_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: a WRAP instance (RST_VAL=5) and a SATURATE instance share all
// inputs and are compared against an integer reference model plus directed expectations.
module tb_updown_mod_counter;
    import counter_pkg::*;

    localparam int unsigned W = 6;

    logic         clk = 1'b0;
    logic         rst_n, srst, load, cnt_en, dir;
    logic [W-1:0] load_val, mod;

    logic [W-1:0] w_data, s_data;
    logic         w_tick, s_tick, w_at_max, s_at_max, w_at_zero, s_at_zero;

    int n_checks = 0;
    int n_errors = 0;

    // model state: index 0 = wrap instance, 1 = saturate instance
    int m_cnt [2];
    bit m_tick[2];

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(W), .RST_VAL(5), .MODE(MODE_WRAP)) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_srst(srst), .i_load(load), .i_load_val(load_val),
        .i_cnt_en(cnt_en), .i_dir(dir), .i_mod(mod), .o_data(w_data), .o_tick(w_tick),
        .o_at_max(w_at_max), .o_at_zero(w_at_zero)
    );

    updown_mod_counter #(.WIDTH(W), .RST_VAL(0), .MODE(MODE_SAT)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_srst(srst), .i_load(load), .i_load_val(load_val),
        .i_cnt_en(cnt_en), .i_dir(dir), .i_mod(mod), .o_data(s_data), .o_tick(s_tick),
        .o_at_max(s_at_max), .o_at_zero(s_at_zero)
    );

    // Advance one clock: model computes from the inputs seen at the edge, sample #1 after.
    task automatic step();
        int  nxt[2];
        bit  tk[2];
        for (int k = 0; k < 2; k++) begin
            int c = m_cnt[k];
            int m = int'(mod);
            tk[k] = 1'b0;
            if (!rst_n)      c = (k == 0) ? 5 : 0;
            else if (srst)   c = 0;
            else if (load)   c = (int'(load_val) < m) ? int'(load_val) : m;
            else if (cnt_en) begin
                if (dir && c >= m) begin
                    tk[k] = 1'b1;
                    if (k == 0) c = 0;
                end else if (!dir && c == 0) begin
                    tk[k] = 1'b1;
                    if (k == 0) c = m;
                end else begin
                    c = dir ? c + 1 : c - 1;
                end
            end
            nxt[k] = c;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = nxt[k];
            m_tick[k] = tk[k];
        end
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; srst = 1'b0; load = 1'b0; cnt_en = 1'b0; dir = DIR_UP; load_val = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0; mod = 6'd59;
        step(); step();
        rst_n = 1'b1;
        n_checks++;
        if (w_data !== 6'd5 || w_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_wrap: data=%0d tick=%b, want data=5 tick=0", w_data, w_tick);
        end
        n_checks++;
        if (s_data !== 6'd0 || s_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_sat: data=%0d tick=%b, want data=0 tick=0", s_data, s_tick);
        end
        // a reset pulse that falls between edges must be ignored
        cnt_en = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        n_checks++;
        if (w_data !== 6'd7) begin
            n_errors++;
            $display("FAIL reset_async_pulse: data=%0d, want 7", w_data);
        end
        cnt_en = 1'b0;
    endtask

    task automatic test_wrap_up();
        idle_inputs();
        srst = 1'b1; step(); srst = 1'b0;
        mod = 6'd59; dir = DIR_UP; cnt_en = 1'b1;
        for (int i = 0; i < 59; i++) step();
        n_checks++;
        if (w_data !== 6'd59 || w_tick !== 1'b0 || w_at_max !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_up_max: data=%0d tick=%b at_max=%b, want 59 0 1",
                     w_data, w_tick, w_at_max);
        end
        step();
        n_checks++;
        if (w_data !== 6'd0 || w_tick !== 1'b1 || w_at_zero !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_up_wrap: data=%0d tick=%b at_zero=%b, want 0 1 1",
                     w_data, w_tick, w_at_zero);
        end
        step();
        n_checks++;
        if (w_data !== 6'd1 || w_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_up_after: data=%0d tick=%b, want 1 0", w_data, w_tick);
        end
        cnt_en = 1'b0;
    endtask

    task automatic test_wrap_down();
        idle_inputs();
        srst = 1'b1; step(); srst = 1'b0;
        mod = 6'd9; dir = DIR_DOWN; cnt_en = 1'b1;
        step();
        n_checks++;
        if (w_data !== 6'd9 || w_tick !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_down_wrap: data=%0d tick=%b, want 9 1", w_data, w_tick);
        end
        step();
        n_checks++;
        if (w_data !== 6'd8 || w_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_down_step: data=%0d tick=%b, want 8 0", w_data, w_tick);
        end
        cnt_en = 1'b0;
    endtask

    task automatic test_load();
        idle_inputs();
        mod = 6'd23; load = 1'b1; load_val = 6'd30; cnt_en = 1'b1;
        step();
        n_checks++;
        if (w_data !== 6'd23 || w_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL load_clamp: data=%0d tick=%b, want 23 0", w_data, w_tick);
        end
        srst = 1'b1;
        step();
        n_checks++;
        if (w_data !== 6'd0 || s_data !== 6'd0) begin
            n_errors++;
            $display("FAIL load_vs_srst: wrap=%0d sat=%0d, want 0 0", w_data, s_data);
        end
        idle_inputs();
    endtask

    task automatic test_saturate();
        idle_inputs();
        srst = 1'b1; step(); srst = 1'b0;
        mod = 6'd3; dir = DIR_UP; cnt_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_checks++;
            if (s_data !== W'((i < 3) ? i : 3) || s_tick !== (i >= 4)) begin
                n_errors++;
                $display("FAIL sat_edge%0d: data=%0d tick=%b, want %0d %b", i, s_data, s_tick,
                         (i < 3) ? i : 3, i >= 4);
            end
        end
        cnt_en = 1'b0;
        step();
        n_checks++;
        if (s_data !== 6'd3 || s_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL sat_disable: data=%0d tick=%b, want 3 0", s_data, s_tick);
        end
    endtask

    task automatic test_mod_change();
        idle_inputs();
        mod = 6'd59; load = 1'b1; load_val = 6'd40;
        step(); load = 1'b0;
        mod = 6'd20; dir = DIR_UP; cnt_en = 1'b1;
        step();
        n_checks++;
        if (w_data !== 6'd0 || w_tick !== 1'b1) begin
            n_errors++;
            $display("FAIL mod_stranded: data=%0d tick=%b, want 0 1", w_data, w_tick);
        end
        mod = 6'd0;
        #1;
        n_checks++;
        if (w_at_max !== 1'b1) begin
            n_errors++;
            $display("FAIL mod_at_max_comb: at_max=%b, want 1", w_at_max);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (w_data !== 6'd0 || w_tick !== 1'b1) begin
                n_errors++;
                $display("FAIL mod_zero_div1: data=%0d tick=%b, want 0 1", w_data, w_tick);
            end
        end
        // srst on a boundary cycle suppresses the tick
        srst = 1'b1;
        step();
        n_checks++;
        if (w_tick !== 1'b0 || s_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL srst_suppress: wrap_tick=%b sat_tick=%b, want 0 0", w_tick, s_tick);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            rst_n    = ($urandom_range(0, 49) != 0);
            srst     = ($urandom_range(0, 29) == 0);
            load     = ($urandom_range(0, 14) == 0);
            load_val = W'($urandom);
            cnt_en   = ($urandom_range(0, 3) != 0);
            dir      = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 19) == 0) mod = W'($urandom_range(0, 63));
            step();
            n_checks++;
            if (int'(w_data) !== m_cnt[0] || w_tick !== m_tick[0] ||
                w_at_max !== (m_cnt[0] == int'(mod)) || w_at_zero !== (m_cnt[0] == 0)) begin
                n_errors++;
                $display("FAIL rand_wrap cyc%0d: data=%0d tick=%b max=%b zero=%b, want %0d %b",
                         n, w_data, w_tick, w_at_max, w_at_zero, m_cnt[0], m_tick[0]);
            end
            n_checks++;
            if (int'(s_data) !== m_cnt[1] || s_tick !== m_tick[1] ||
                s_at_max !== (m_cnt[1] == int'(mod)) || s_at_zero !== (m_cnt[1] == 0)) begin
                n_errors++;
                $display("FAIL rand_sat cyc%0d: data=%0d tick=%b max=%b zero=%b, want %0d %b",
                         n, s_data, s_tick, s_at_max, s_at_zero, m_cnt[1], m_tick[1]);
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_cnt[0] = 0; m_cnt[1] = 0; m_tick[0] = 1'b0; m_tick[1] = 1'b0;
        idle_inputs();
        mod = 6'd59;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_load();
        test_saturate();
        test_mod_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter with a runtime-programmable terminal value, synchronous parallel load, wrap or saturate mode, and a registered boundary tick for cascading. It generalises the fixed-modulus up-counter used in the clock datapath. Seconds, minutes and hours stages, and set-time/count-down modes, chain `o_tick` of one stage into `i_cnt_en` of the next.

## Interface
- `WIDTH`, default 6: counter and modulus width in bits.
- `RST_VAL`, default 0: value loaded on `i_rst_n` low. Must be ≤ 2^WIDTH−1.
- `MODE`, default 0: 0 = WRAP, 1 = SATURATE.

Ports:
- `i_clk`, in, 1: sole clock, rising edge.
- `i_rst_n`, in, 1: synchronous active-low reset, sampled on the `i_clk` rising edge.
- `i_srst`, in, 1: synchronous clear to 0.
- `i_load`, in, 1: synchronous parallel load.
- `i_load_val`, in, WIDTH: value for load.
- `i_cnt_en`, in, 1: count enable, one step per enabled cycle.
- `i_dir`, in, 1: 1 = up, 0 = down.
- `i_mod`, in, WIDTH: terminal value. Counting range is 0..`i_mod` inclusive.
- `o_data`, out, WIDTH: current count (register output).
- `o_tick`, out, 1: registered boundary pulse.
- `o_at_max`, out, 1: combinational, `o_data == i_mod`.
- `o_at_zero`, out, 1: combinational, `o_data == 0`.

## Operation
- Priority per rising edge: `!i_rst_n` > `i_srst` > `i_load` > `i_cnt_en` > hold.
- Reset: `cnt` = `RST_VAL`, `o_tick` = 0.
- `i_srst`: `cnt` = 0, `o_tick` = 0.
- Load: `cnt` = min(`i_load_val`, `i_mod`), `o_tick` = 0. A load never generates a tick.
- Boundary event `bnd` = `i_cnt_en` & ((`i_dir` & `cnt` ≥ `i_mod`) | (!`i_dir` & `cnt` == 0)). Only the `i_cnt_en` branch asserts it.
- WRAP mode:
  - Up: `cnt` = 0 on `bnd`, else `cnt` + 1.
  - Down: `cnt` = `i_mod` on `bnd`, else `cnt` − 1.
- SATURATE mode: `cnt` holds on `bnd`, otherwise steps as in WRAP.
- `o_tick` <= `bnd` in both modes, gated by the priority above. In SATURATE, `o_tick` stays high on every enabled cycle spent at the bound.
- Arithmetic is modulo 2^WIDTH internally. The `≥` compare means a count stranded above a reduced `i_mod` wraps to 0 (up) on its next enabled step, with a tick.
  - Counting down from a stranded value decrements normally and re-enters the range.
- `i_mod` = 0: `cnt` stays 0 and every enabled cycle ticks (divide-by-1).
- `i_dir` and `i_mod` may change on any cycle and take effect on the same edge.

## Timing
- `o_data` updates on the edge where the condition is sampled, so it has 1 cycle of latency from inputs.
- `o_tick` is high for exactly the cycle following the boundary edge. In WRAP-up, that is the cycle where `o_data` first shows 0.
  - A downstream stage sampling `o_tick` as `i_cnt_en` therefore steps one cycle after the wrap. This is the required cascade behaviour.
- `o_at_max` and `o_at_zero` are combinational from `cnt` and `i_mod`, so they follow `i_mod` changes in the same cycle.
- Reset or `i_srst` asserted mid-count, including on a boundary cycle, suppresses that cycle's tick.

## Structure
- `counter_pkg` holds:
  - `MODE_WRAP` = 0, `MODE_SAT` = 1.
  - `DIR_DOWN` = 0, `DIR_UP` = 1.
  - Default widths for the clock stages: seconds and minutes are 6 bits with `i_mod` 59; hours are 5 bits with `i_mod` 23.
- Single module, no sub-module. The next-state mux and boundary detect are one combinational block feeding two registers (`cnt`, `o_tick`).
- A `clock_chain` top instantiating three `updown_mod_counter` stages is the intended consumer. It is out of scope here.

## Test plan
- **Reset:** `RST_VAL`=5, hold `i_rst_n`=0 for 2 edges then release → `o_data`=5, `o_tick`=0. Asynchronous pulses of `i_rst_n` between edges have no effect.
- **WRAP up:** `i_mod`=59, `i_dir`=1, `i_cnt_en`=1 from 0 → 59 after 59 edges. Next edge gives `o_data`=0 and `o_tick`=1 for one cycle only, and the 61st edge gives `o_data`=1.
- **WRAP down:** `i_mod`=9, `cnt`=0, `i_dir`=0, enable → `o_data`=9 with `o_tick`=1. Next edge gives 8 with `o_tick`=0.
- **Load:** `i_mod`=23, `i_load`=1, `i_load_val`=30 → `o_data`=23, no tick. Repeat with `i_load` and `i_srst` both high → `o_data`=0.
- **SATURATE:** `MODE`=1, `i_mod`=3, up for 6 edges → `o_data` sticks at 3 and `o_tick` is high on edges 4–6. Dropping `i_cnt_en` gives `o_tick`=0 the next cycle.
- **Modulus change:** `cnt`=40, then `i_mod` changes 59→20 with up-enable → next edge gives `o_data`=0, `o_tick`=1. With `i_mod`=0, every enabled cycle ticks.
